// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider: DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Signed ops, sign correction and overflow detection need `DIV_SIGNED_EN; otherwise DIV/REM act as DIVU/REMU.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] ALUop1,
  input  logic [WIDTH-1:0] regOp2,
  input  logic [4:0]       rd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(WIDTH);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic             want_rem;
  logic             neg_q;
  logic             neg_r;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             ovf;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [CNT_W-1:0] cnt_n;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

`ifdef DIV_SIGNED_EN
  assign is_signed = ~op[0];
`else
  logic unused_op;
  assign is_signed = 1'b0;
  assign unused_op = op[0];
`endif

  // Operands are converted to magnitudes up front so the iteration is purely unsigned.
  assign a_neg    = is_signed & ALUop1[WIDTH-1];
  assign b_neg    = is_signed & regOp2[WIDTH-1];
  assign a_mag    = a_neg ? -ALUop1 : ALUop1;
  assign b_mag    = b_neg ? -regOp2 : regOp2;
  assign div_zero = (regOp2 == '0);
  assign ovf      = is_signed & (ALUop1 == MOST_NEG) & (&regOp2);

  assign busy = (state != S_IDLE);

  // NOTE: always_comb with a full assignment on every path, so no latch is inferred.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvsr};
    if (!diff[WIDTH]) begin
      rem_n = diff[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_n = rem_sh[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b0};
    end
    cnt_n = cnt + CNT_W'(1);
    q_fin = neg_q ? -quo_n : quo_n;
    r_fin = neg_r ? -rem_n : rem_n;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      want_rem <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_out   <= rd;
            want_rem <= op[1];
            cnt      <= '0;
            if (div_zero) begin
              state  <= S_FIN;
              done   <= 1'b1;
              result <= op[1] ? ALUop1 : '1;
            end else if (ovf) begin
              state  <= S_FIN;
              done   <= 1'b1;
              result <= op[1] ? '0 : MOST_NEG;
            end else begin
              state <= S_CALC;
              quo   <= a_mag;
              rem   <= '0;
              dvsr  <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        S_CALC: begin
          quo <= quo_n;
          rem <= rem_n;
          cnt <= cnt_n;
          // The last iteration is folded into the result write so done lands WIDTH edges after start.
          if (cnt_n == CNT_END) begin
            state  <= S_FIN;
            done   <= 1'b1;
            result <= want_rem ? r_fin : q_fin;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random ops against an arithmetic model.
module tb_div_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] ALUop1 = '0;
  logic [WIDTH-1:0] regOp2 = '0;
  logic [4:0]       rd = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       rd_out;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .ALUop1(ALUop1), .regOp2(regOp2),
    .rd(rd), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit signed_op(input logic [1:0] o);
`ifdef DIV_SIGNED_EN
    return !o[0];
`else
    return (o == 2'b11) && 1'b0;
`endif
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (b == 0) || (signed_op(o) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [WIDTH-1:0] ref_model(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (signed_op(o)) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
      return o[1] ? sa % sb : sa / sb;
    end
    return o[1] ? a % b : a / b;
  endfunction

  // Entered and left at a negedge; the next call may therefore start back-to-back.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [4:0] r, input int ign_at);
    logic [WIDTH-1:0] exp_res;
    int exp_lat;
    int lat;
    bit seen;
    exp_res = ref_model(o, a, b);
    exp_lat = is_special(o, a, b) ? 0 : WIDTH;
    check($sformatf("%s_idle", tag), WIDTH'(busy), 0);
    op = o; ALUop1 = a; regOp2 = b; rd = r; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom_range(0, 3)); ALUop1 = $urandom; regOp2 = $urandom; rd = 5'($urandom);
    check($sformatf("%s_busy", tag), WIDTH'(busy), 1);
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (i == ign_at) begin
        start = 1'b1; ALUop1 = $urandom; regOp2 = 32'd3; op = 2'b01; rd = ~r;
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
      else lat++;
    end
    start = 1'b0;
    check($sformatf("%s_seen", tag), WIDTH'(seen), 1);
    check($sformatf("%s_lat", tag), lat, exp_lat);
    check($sformatf("%s_res", tag), result, exp_res);
    check($sformatf("%s_rd", tag), WIDTH'(rd_out), WIDTH'(r));
    @(negedge clk);
    check($sformatf("%s_pulse", tag), WIDTH'(done), 0);
    check($sformatf("%s_hold", tag), result, exp_res);
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nodone;
    logic [1:0]       o;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", WIDTH'(busy), 0);
    check("rst_done", WIDTH'(done), 0);
    check("rst_result", result, 0);
    check("rst_rd_out", WIDTH'(rd_out), 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd9, -1);
    check("divu_100_7_const", result, 32'd14);
    do_op("rem_m7_2", 2'b10, -32'sd7, 32'd2, 5'd3, -1);
    do_op("div_m7_2", 2'b00, -32'sd7, 32'd2, 5'd4, -1);
`ifdef DIV_SIGNED_EN
    check("div_m7_2_const", result, 32'hFFFF_FFFD);
`endif
    do_op("divu_5_0", 2'b01, 32'd5, 32'd0, 5'd5, -1);
    do_op("remu_5_0", 2'b11, 32'd5, 32'd0, 5'd6, -1);
    check("remu_5_0_const", result, 32'd5);
    do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, -1);
    do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, -1);
    do_op("divu_max", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd10, -1);
    do_op("ignore", 2'b01, 32'd1000, 32'd9, 5'd11, 9);

    // Abandon an operation with an asynchronous reset mid-flight.
    op = 2'b01; ALUop1 = 32'd12345; regOp2 = 32'd10; rd = 5'd12; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", WIDTH'(busy), 0);
    check("mid_rst_done", WIDTH'(done), 0);
    check("mid_rst_result", result, 0);
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    nodone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) nodone++;
    end
    check("mid_rst_quiet", nodone, 0);
    do_op("after_rst", 2'b11, 32'd1000, 32'd7, 5'd13, -1);

    for (int k = 0; k < 40; k++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = b >> $urandom_range(1, 31);
        default: ;
      endcase
      do_op($sformatf("rnd%0d", k), o, a, b, 5'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port ALUop1  input  WIDTH  dividend, from register file rs1 read port.
REQ-008 SHALL have port regOp2  input  WIDTH  divisor, from register file rs2 read port.
REQ-009 SHALL have port rd  input  5  destination register tag, carried with the request.
REQ-010 SHALL have port busy  output  1  high while a request is in progress; upstream must stall.
REQ-011 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-012 SHALL have port result  output  WIDTH  quotient or remainder per op; feeds WD3 of the register file.
REQ-013 SHALL have port rd_out  output  5  captured rd tag, valid with done; feeds register file rd.

Function
REQ-014 SHALL implement states IDLE, CALC, FIN; IDLE->CALC on start, IDLE->FIN on a special case, CALC->FIN when counter reaches WIDTH, FIN->IDLE unconditionally.
REQ-015 SHALL, on start in IDLE, capture ALUop1, regOp2, op and rd in the same edge; later input changes have no effect.
REQ-016 SHALL ignore start while busy is high; no queuing.
REQ-017 SHALL assert busy from the edge after accepted start until the edge that leaves FIN; busy low in IDLE.
REQ-018 SHALL perform radix-2 restoring division, one quotient bit per CALC cycle, on operand magnitudes.
REQ-019 SHALL assert done in FIN for exactly one cycle; normal latency is start edge N -> done high during cycle N+WIDTH+1.
REQ-020 SHALL, for signed ops, give a quotient sign of sign(dividend) XOR sign(divisor) and a remainder sign equal to the dividend sign; quotient truncates toward zero.
REQ-021 SHALL, on divisor 0, skip CALC: quotient = all ones, remainder = dividend; done during cycle N+1.
REQ-022 SHALL, on signed overflow (dividend = most-negative, divisor = -1, op DIV/REM), skip CALC: quotient = most-negative, remainder = 0; done during cycle N+1.
REQ-023 SHALL hold result and rd_out stable from done until the next accepted start.
REQ-024 SHALL accept a new start in the cycle immediately after done, i.e. back-to-back operations.

Reset
REQ-025 SHALL, on rst high and independent of clk, force state IDLE, busy 0, done 0, result 0, rd_out 0, counter 0.
REQ-026 SHALL abandon any in-progress operation on reset; done is not produced for it.
REQ-027 SHALL ignore start while rst is high; the first start is sampled on the first posedge after release.

Configuration
REQ-028 SHALL, with DIV_SIGNED_EN defined, support all four ops per REQ-020 and REQ-022.
REQ-029 SHALL, without DIV_SIGNED_EN, treat DIV as DIVU and REM as REMU, omit sign correction and overflow detection; divide-by-zero handling per REQ-021 is retained.

Verification
REQ-030 SHALL cover: DIVU 100/7 -> done at N+33, result 14, rd_out equals input rd.
REQ-031 SHALL cover: REM -7 % 2 (DIV_SIGNED_EN) -> result 0xFFFFFFFF; DIV -7/2 -> 0xFFFFFFFD.
REQ-032 SHALL cover: DIVU 5/0 -> done at N+1, result 0xFFFFFFFF; REMU 5/0 -> result 5.
REQ-033 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> done at N+1, result 0x80000000; REM -> 0.
REQ-034 SHALL cover: second start at N+10 during busy -> ignored; only the first result appears, at N+33.
REQ-035 SHALL cover: rst pulse at N+15 -> busy, done and result 0 immediately; no done follows; a new start after release completes normally.
